// File: rtl/aes_pkg.sv
// Shared AES definitions: segment encoding, paging width, state state/message transpose.
package aes_pkg;

  localparam int PAGE_W = 2;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Active-low segments, bit6..bit0 = g..a, indexed by nibble value.
  localparam logic [6:0] SEG_TABLE [0:15] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_SHOW  = 1'b1
  } pager_state_t;

  // A 4x4 byte transpose is its own inverse, so one function serves both directions.
  function automatic logic [0:127] transpose_state(input logic [0:127] i_blk);
    logic [0:127] r_out;
    r_out = '0;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        r_out[8*(4*c+r) +: 8] = i_blk[8*(4*r+c) +: 8];
      end
    end
    return r_out;
  endfunction

endpackage

// File: rtl/hex_to_seg7.sv
// Nibble to active-low seven-segment decoder.
module hex_to_seg7
  import aes_pkg::*;
(
  input  logic [3:0] i_nib,
  output logic [6:0] o_seg
);

  assign o_seg = SEG_TABLE[i_nib];

endmodule

// File: rtl/hex_result_pager.sv
// Captures the AES result state, restores message byte order and pages it onto HEX7..HEX0.
module hex_result_pager
  import aes_pkg::*;
#(
  parameter int unsigned DWELL_CYCLES = 8000000
) (
  input  logic              clock,
  input  logic              resetN,
  input  logic              done,
  input  logic [0:127]      stateIn,
  input  logic              nextPage,
  input  logic              autoScroll,
  output logic [0:127]      messageOut,
  output logic              valid,
  output logic [PAGE_W-1:0] page,
  output logic [6:0]        HEX0,
  output logic [6:0]        HEX1,
  output logic [6:0]        HEX2,
  output logic [6:0]        HEX3,
  output logic [6:0]        HEX4,
  output logic [6:0]        HEX5,
  output logic [6:0]        HEX6,
  output logic [6:0]        HEX7
);

  localparam int CNT_W = (DWELL_CYCLES > 2) ? $clog2(DWELL_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_TC = CNT_W'(DWELL_CYCLES - 1);

  pager_state_t      r_state;
  pager_state_t      w_state_nxt;
  logic              r_done_q;
  logic              r_np_s1;
  logic              r_np_s2;
  logic              r_np_q;
  logic [0:127]      r_msg;
  logic [PAGE_W-1:0] r_page;
  logic [PAGE_W-1:0] w_page_nxt;
  logic [CNT_W-1:0]  r_cnt;
  logic [CNT_W-1:0]  w_cnt_nxt;
  logic              w_capture;
  logic              w_np_rise;
  logic              w_dwell_tc;
  logic [6:0]        r_hex [8];
  logic [6:0]        w_seg [8];
  logic [3:0]        w_nib [8];

  assign w_capture  = done & ~r_done_q;
  assign w_np_rise  = r_np_s2 & ~r_np_q;
  assign w_dwell_tc = autoScroll && (r_cnt == CNT_TC);

  // Edge detect on done and two-flop synchronizer for the asynchronous button.
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      r_done_q <= 1'b0;
      r_np_s1  <= 1'b0;
      r_np_s2  <= 1'b0;
      r_np_q   <= 1'b0;
    end else begin
      r_done_q <= done;
      r_np_s1  <= nextPage;
      r_np_s2  <= r_np_s1;
      r_np_q   <= r_np_s2;
    end
  end

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      r_state <= ST_EMPTY;
      r_page  <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_page  <= w_page_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Capture outranks paging; a button edge and a dwell expiry together advance once.
  always_comb begin
    w_state_nxt = r_state;
    w_page_nxt  = r_page;
    w_cnt_nxt   = r_cnt;
    if (w_capture) begin
      w_state_nxt = ST_SHOW;
      w_page_nxt  = '0;
      w_cnt_nxt   = '0;
    end else if (r_state == ST_SHOW) begin
      if (w_np_rise || w_dwell_tc) begin
        w_page_nxt = r_page + 1'b1;
        w_cnt_nxt  = '0;
      end else if (autoScroll) begin
        w_cnt_nxt = r_cnt + 1'b1;
      end else begin
        w_cnt_nxt = '0;
      end
    end
  end

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      r_msg <= '0;
    end else if (w_capture) begin
      r_msg <= transpose_state(stateIn);
    end
  end

  // Digit g covers nibble 8*page+g; digit 0 drives HEX7 (high nibble of the page's first byte).
  for (genvar g = 0; g < 8; g++) begin : g_digit
    logic [6:0] w_idx;
    assign w_idx    = {r_page, 3'(g), 2'b00};
    assign w_nib[g] = r_msg[w_idx +: 4];

    hex_to_seg7 u_seg (
      .i_nib (w_nib[g]),
      .o_seg (w_seg[g])
    );
  end

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      for (int i = 0; i < 8; i++) r_hex[i] <= SEG_BLANK;
    end else begin
      for (int i = 0; i < 8; i++) begin
        r_hex[i] <= (r_state == ST_SHOW) ? w_seg[i] : SEG_BLANK;
      end
    end
  end

  assign messageOut = r_msg;
  assign valid      = (r_state == ST_SHOW);
  assign page       = r_page;
  assign HEX7       = r_hex[0];
  assign HEX6       = r_hex[1];
  assign HEX5       = r_hex[2];
  assign HEX4       = r_hex[3];
  assign HEX3       = r_hex[4];
  assign HEX2       = r_hex[5];
  assign HEX1       = r_hex[6];
  assign HEX0       = r_hex[7];

endmodule

// File: tb/tb_hex_result_pager.sv
// Directed bench for hex_result_pager with a short dwell period.
module tb_hex_result_pager;

  logic         clock;
  logic         resetN;
  logic         done;
  logic [0:127] stateIn;
  logic         nextPage;
  logic         autoScroll;
  logic [0:127] messageOut;
  logic         valid;
  logic [1:0]   page;
  logic [6:0]   HEX0, HEX1, HEX2, HEX3, HEX4, HEX5, HEX6, HEX7;

  int n_checks;
  int n_errors;

  hex_result_pager #(.DWELL_CYCLES(4)) dut (
    .clock      (clock),
    .resetN     (resetN),
    .done       (done),
    .stateIn    (stateIn),
    .nextPage   (nextPage),
    .autoScroll (autoScroll),
    .messageOut (messageOut),
    .valid      (valid),
    .page       (page),
    .HEX0       (HEX0),
    .HEX1       (HEX1),
    .HEX2       (HEX2),
    .HEX3       (HEX3),
    .HEX4       (HEX4),
    .HEX5       (HEX5),
    .HEX6       (HEX6),
    .HEX7       (HEX7)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic pulse_button();
    nextPage = 1'b1;
    repeat (5) @(negedge clock);
    nextPage = 1'b0;
    repeat (5) @(negedge clock);
  endtask

  task automatic test_empty_button();
    for (int i = 0; i < 3; i++) pulse_button();
    n_checks++;
    if (page !== 2'd0) begin
      n_errors++;
      $display("FAIL empty_page got %0d want 0", page);
    end
    n_checks++;
    if (valid !== 1'b0) begin
      n_errors++;
      $display("FAIL empty_valid got %0b want 0", valid);
    end
    n_checks++;
    if ({HEX7, HEX6, HEX5, HEX4, HEX3, HEX2, HEX1, HEX0} !== {8{7'h7F}}) begin
      n_errors++;
      $display("FAIL empty_hex got %h want all 7f",
               {HEX7, HEX6, HEX5, HEX4, HEX3, HEX2, HEX1, HEX0});
    end
  endtask

  task automatic test_capture();
    stateIn = 128'h000102030405060708090a0b0c0d0e0f;
    done = 1'b1;
    @(negedge clock);
    n_checks++;
    if (messageOut !== 128'h0004080c0105090d02060a0e03070b0f) begin
      n_errors++;
      $display("FAIL capture_msg got %h want 0004080c0105090d02060a0e03070b0f", messageOut);
    end
    n_checks++;
    if (valid !== 1'b1) begin
      n_errors++;
      $display("FAIL capture_valid got %0b want 1", valid);
    end
    @(negedge clock);
    n_checks++;
    if ({HEX7, HEX6, HEX5, HEX4, HEX3, HEX2, HEX1, HEX0} !==
        {7'h40, 7'h40, 7'h40, 7'h19, 7'h40, 7'h00, 7'h40, 7'h46}) begin
      n_errors++;
      $display("FAIL capture_hex_p0 got %h want 40,40,40,19,40,00,40,46 packed",
               {HEX7, HEX6, HEX5, HEX4, HEX3, HEX2, HEX1, HEX0});
    end
    done = 1'b0;
    @(negedge clock);
  endtask

  task automatic test_paging();
    logic [1:0] exp_pages [4];
    exp_pages = '{2'd1, 2'd2, 2'd3, 2'd0};
    for (int i = 0; i < 4; i++) begin
      pulse_button();
      n_checks++;
      if (page !== exp_pages[i]) begin
        n_errors++;
        $display("FAIL paging_step%0d got %0d want %0d", i, page, exp_pages[i]);
      end
      if (i == 2) begin
        n_checks++;
        if ({HEX7, HEX6, HEX5, HEX4, HEX3, HEX2, HEX1, HEX0} !==
            {7'h40, 7'h30, 7'h40, 7'h78, 7'h40, 7'h03, 7'h40, 7'h0E}) begin
          n_errors++;
          $display("FAIL paging_hex_p3 got %h want 40,30,40,78,40,03,40,0e packed",
                   {HEX7, HEX6, HEX5, HEX4, HEX3, HEX2, HEX1, HEX0});
        end
      end
    end
  endtask

  task automatic test_autoscroll();
    logic [1:0] exp_pg;
    done = 1'b1;
    @(negedge clock);
    done = 1'b0;
    autoScroll = 1'b1;
    n_checks++;
    if (page !== 2'd0) begin
      n_errors++;
      $display("FAIL auto_start got %0d want 0", page);
    end
    for (int k = 1; k <= 4; k++) begin
      repeat (3) @(negedge clock);
      exp_pg = 2'(k - 1);
      n_checks++;
      if (page !== exp_pg) begin
        n_errors++;
        $display("FAIL auto_hold%0d got %0d want %0d", k, page, exp_pg);
      end
      @(negedge clock);
      exp_pg = 2'(k);
      n_checks++;
      if (page !== exp_pg) begin
        n_errors++;
        $display("FAIL auto_step%0d got %0d want %0d", k, page, exp_pg);
      end
    end
    autoScroll = 1'b0;
    repeat (10) @(negedge clock);
    n_checks++;
    if (page !== 2'd0) begin
      n_errors++;
      $display("FAIL auto_freeze got %0d want 0", page);
    end
  endtask

  task automatic test_done_hold();
    stateIn = 128'h00112233445566778899aabbccddeeff;
    done = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      if (i == 2) stateIn = 128'hffeeddccbbaa99887766554433221100;
    end
    n_checks++;
    if (messageOut !== 128'h004488cc115599dd2266aaee3377bbff) begin
      n_errors++;
      $display("FAIL hold_msg got %h want 004488cc115599dd2266aaee3377bbff", messageOut);
    end
    done = 1'b0;
    pulse_button();
    n_checks++;
    if (page !== 2'd1) begin
      n_errors++;
      $display("FAIL hold_page_adv got %0d want 1", page);
    end
    nextPage = 1'b1;
    @(negedge clock);
    @(negedge clock);
    done = 1'b1;
    @(negedge clock);
    n_checks++;
    if (page !== 2'd0) begin
      n_errors++;
      $display("FAIL race_page got %0d want 0", page);
    end
    n_checks++;
    if (messageOut !== 128'hffbb7733eeaa6622dd995511cc884400) begin
      n_errors++;
      $display("FAIL race_msg got %h want ffbb7733eeaa6622dd995511cc884400", messageOut);
    end
    repeat (3) @(negedge clock);
    n_checks++;
    if (page !== 2'd0) begin
      n_errors++;
      $display("FAIL race_settle got %0d want 0", page);
    end
    nextPage = 1'b0;
    done = 1'b0;
    repeat (3) @(negedge clock);
  endtask

  task automatic test_reset();
    pulse_button();
    @(negedge clock);
    #2;
    resetN = 1'b0;
    #1;
    n_checks++;
    if ({HEX7, HEX6, HEX5, HEX4, HEX3, HEX2, HEX1, HEX0} !== {8{7'h7F}}) begin
      n_errors++;
      $display("FAIL reset_hex got %h want all 7f",
               {HEX7, HEX6, HEX5, HEX4, HEX3, HEX2, HEX1, HEX0});
    end
    n_checks++;
    if (valid !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_valid got %0b want 0", valid);
    end
    n_checks++;
    if (messageOut !== 128'h0) begin
      n_errors++;
      $display("FAIL reset_msg got %h want 0", messageOut);
    end
    n_checks++;
    if (page !== 2'd0) begin
      n_errors++;
      $display("FAIL reset_page got %0d want 0", page);
    end
    @(negedge clock);
    resetN = 1'b1;
    @(negedge clock);
  endtask

  initial begin
    n_checks   = 0;
    n_errors   = 0;
    resetN     = 1'b0;
    done       = 1'b0;
    stateIn    = '0;
    nextPage   = 1'b0;
    autoScroll = 1'b0;
    repeat (3) @(negedge clock);
    resetN = 1'b1;
    @(negedge clock);
    test_empty_button();
    test_capture();
    test_paging();
    test_autoscroll();
    test_done_hold();
    test_reset();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
